// File: rtl/seg7_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_pkg : shared 7-segment glyph set, bit ordering and decoder FSM states.
// Revision : 1.0
// ---------------------------------------------------------------------------
package seg7_pkg;

  // Pattern bit ordering: bit6 = segment A ... bit0 = segment G, 1 = lit.
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [6:0] PAT_BLANK = 7'h00;

  localparam logic [6:0] GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic [0:0] {
    S_TRACK  = 1'b0,
    S_LOCKED = 1'b1
  } seg7_state_e;

  function automatic logic [6:0] seg7_encode(input logic [3:0] num);
    return GLYPH[num];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_binary_decoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_to_binary_decoder_if : segment pins in, decoded digit/status out.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface seg7_to_binary_decoder_if;
  logic       i_Segment_A;
  logic       i_Segment_B;
  logic       i_Segment_C;
  logic       i_Segment_D;
  logic       i_Segment_E;
  logic       i_Segment_F;
  logic       i_Segment_G;
  logic [3:0] o_Binary_Num;
  logic       o_Valid;
  logic       o_Blank;
  logic       o_Update;
  logic       o_Error;

  modport master (
    output i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
           i_Segment_E, i_Segment_F, i_Segment_G,
    input  o_Binary_Num, o_Valid, o_Blank, o_Update, o_Error
  );

  modport slave (
    input  i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
           i_Segment_E, i_Segment_F, i_Segment_G,
    output o_Binary_Num, o_Valid, o_Blank, o_Update, o_Error
  );
endinterface
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_pattern_decode : active-high 7-bit pattern -> hex digit, legal, blank.
// Revision : 1.0
// ---------------------------------------------------------------------------
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] num_o,
  output logic       legal_o,
  output logic       blank_o
);

  always_comb begin
    num_o   = 4'h0;
    legal_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == GLYPH[i]) begin
        num_o   = 4'(i);
        legal_o = 1'b1;
      end
    end
  end

  assign blank_o = (pattern_i == PAT_BLANK);

endmodule
`default_nettype wire

// File: rtl/seg7_to_binary_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_to_binary_decoder : synchronise, debounce and decode active-low
// segment lines into a hex digit with blank/illegal status and event pulses.
// Revision : 1.0
// ---------------------------------------------------------------------------
module seg7_to_binary_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  seg7_to_binary_decoder_if.slave   bus
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
    $error("seg7_to_binary_decoder: STABLE_CYCLES must be in 1..255");
  end

  localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       pins;
  logic [6:0]       sync1_q;
  logic [6:0]       sync2_q;
  logic [6:0]       pattern;
  logic [6:0]       prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             same;
  logic             count_done;

  seg7_state_e      state_q;
  logic [6:0]       stored_q;
  logic [3:0]       num_q;
  logic             valid_q;
  logic             blank_q;
  logic             update_q;
  logic             error_q;

  logic [3:0]       dec_num;
  logic             dec_legal;
  logic             dec_blank;

  assign pins = {bus.i_Segment_A, bus.i_Segment_B, bus.i_Segment_C,
                 bus.i_Segment_D, bus.i_Segment_E, bus.i_Segment_F,
                 bus.i_Segment_G};

  // Reset to all-ones on the pins so the internal pattern starts blank.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1_q <= 7'h7F;
      sync2_q <= 7'h7F;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
    end
  end

  assign pattern    = ~sync2_q;
  assign same       = (pattern == prev_q);
  assign count_done = same && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      prev_q <= PAT_BLANK;
      cnt_q  <= '0;
    end else begin
      prev_q <= pattern;
      cnt_q  <= cnt_d;
    end
  end

  seg7_pattern_decode u_decode (
    .pattern_i (pattern),
    .num_o     (dec_num),
    .legal_o   (dec_legal),
    .blank_o   (dec_blank)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q  <= S_LOCKED;
      stored_q <= PAT_BLANK;
      num_q    <= 4'h0;
      valid_q  <= 1'b0;
      blank_q  <= 1'b1;
      update_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      update_q <= 1'b0;
      error_q  <= 1'b0;
      case (state_q)
        S_TRACK: begin
          if (count_done) begin
            state_q <= S_LOCKED;
            // Re-settling on the already accepted pattern is silent.
            if (pattern != stored_q) begin
              stored_q <= pattern;
              if (dec_legal) begin
                num_q    <= dec_num;
                valid_q  <= 1'b1;
                blank_q  <= 1'b0;
                update_q <= 1'b1;
              end else if (dec_blank) begin
                valid_q  <= 1'b0;
                blank_q  <= 1'b1;
              end else begin
                valid_q  <= 1'b0;
                blank_q  <= 1'b0;
                error_q  <= 1'b1;
              end
            end
          end
        end
        S_LOCKED: begin
          if (!same) begin
            state_q <= S_TRACK;
          end
        end
        default: state_q <= S_LOCKED;
      endcase
    end
  end

  assign bus.o_Binary_Num = num_q;
  assign bus.o_Valid      = valid_q;
  assign bus.o_Blank      = blank_q;
  assign bus.o_Update     = update_q;
  assign bus.o_Error      = error_q;

endmodule
`default_nettype wire
